// File: rtl/lcd_pkg.sv
// Shared types and field decode for the LCD instruction sequencer.
// Instruction word: {rs, db[7:0]}; clear/home is rs=0 with db[7:2]=0.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT,
      S_FIN
   } state_t;

   localparam int W_WORD = 9;
   localparam int RS_BIT = 8;
   localparam int DB_MSB = 7;
   localparam int DB_LSB = 0;
   localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

   function automatic logic [7:0] bus_fmt(
      input logic [7:0] db,
      input logic       bus4,
      input logic       low
   );
      if (!bus4) return db;
      return low ? {db[3:0], 4'h0} : {db[7:4], 4'h0};
   endfunction

   function automatic logic is_long(input logic [W_WORD-1:0] w);
      return !w[RS_BIT] && ((w[DB_MSB:DB_LSB] & CLR_HOME_MASK) == 8'h00);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Shared phase down-counter; o_expire marks the last cycle of a phase.
module lcd_delay_timer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [W-1:0] i_load,
   output logic         o_expire
);

   localparam logic [W-1:0] L_ONE = W'(1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= i_load;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - L_ONE;
      end
   end

   assign o_expire = (r_cnt == L_ONE);

endmodule

// File: rtl/lcd_sequencer.sv
// Plays a table of HD44780-style instructions onto the LCD bus,
// with setup/pulse/hold/exec timing and optional 4-bit nibble mode.
module lcd_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int BUS4    = 0,
   parameter int T_SETUP = 4,
   parameter int T_PW    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_LONG  = 80000
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [$clog2(DEPTH):0]   num_instr,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [8:0]               wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               lcd_db,
   output logic                     lcd_e,
   output logic                     lcd_rw,
   output logic                     lcd_rs
);

   localparam int AW   = $clog2(DEPTH);
   localparam int M1   = (T_LONG > T_EXEC) ? T_LONG : T_EXEC;
   localparam int M2   = (M1 > T_PW) ? M1 : T_PW;
   localparam int M3   = (M2 > T_SETUP) ? M2 : T_SETUP;
   localparam int TMAX = (M3 > T_HOLD) ? M3 : T_HOLD;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic          B4      = (BUS4 != 0);
   localparam logic [AW:0]   L_DEPTH = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   L_ONE   = (AW + 1)'(1);
   localparam logic [TW-1:0] L_SETUP = TW'(T_SETUP);
   localparam logic [TW-1:0] L_PW    = TW'(T_PW);
   localparam logic [TW-1:0] L_HOLD  = TW'(T_HOLD);
   localparam logic [TW-1:0] L_EXEC  = TW'(T_EXEC);
   localparam logic [TW-1:0] L_LONG  = TW'(T_LONG);

   logic [W_WORD-1:0] r_tab [DEPTH];
   state_t            r_state;
   logic [AW:0]       r_i;
   logic [AW:0]       r_num;
   logic [W_WORD-1:0] r_word;
   logic              r_nib;
   logic              r_busy;
   logic              r_done;
   logic              r_zpend;
   logic              r_e;
   logic              r_rs;
   logic [7:0]        r_db;

   logic [AW:0]       w_num;
   logic [AW:0]       w_next_i;
   logic [W_WORD-1:0] w_next_word;
   logic [W_WORD-1:0] w_first_word;
   logic              w_expire;
   logic              w_tstart;
   logic [TW-1:0]     w_tload;

   assign w_num        = (num_instr > L_DEPTH) ? L_DEPTH : num_instr;
   assign w_next_i     = r_i + L_ONE;
   assign w_next_word  = r_tab[w_next_i[AW-1:0]];
   assign w_first_word = r_tab[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_tab[k] <= '0;
      end else if (wr_en && !r_busy) begin
         r_tab[wr_addr] <= wr_data;
      end
   end

   // Timer is reloaded on every phase boundary
   always_comb begin
      w_tstart = 1'b0;
      w_tload  = '0;
      unique case (1'b1)
         (r_state == S_LOAD): begin
            w_tstart = 1'b1;
            w_tload  = L_SETUP;
         end
         (r_state == S_SETUP): begin
            w_tstart = w_expire;
            w_tload  = L_PW;
         end
         (r_state == S_PULSE): begin
            w_tstart = w_expire;
            w_tload  = L_HOLD;
         end
         (r_state == S_HOLD): begin
            w_tstart = w_expire;
            if (B4 && !r_nib)         w_tload = L_SETUP;
            else if (is_long(r_word)) w_tload = L_LONG;
            else                      w_tload = L_EXEC;
         end
         default: ;
      endcase
   end

   lcd_delay_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_tstart),
      .i_load   (w_tload),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_num   <= '0;
         r_word  <= '0;
         r_nib   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_zpend <= 1'b0;
         r_e     <= 1'b0;
         r_rs    <= 1'b0;
         r_db    <= '0;
      end else begin
         r_done  <= r_zpend;
         r_zpend <= 1'b0;
         if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_nib   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= '0;
         end else begin
            case (r_state)
               S_IDLE: if (start && !abort) begin
                  if (w_num == '0) begin
                     r_zpend <= 1'b1;
                  end else begin
                     r_state <= S_LOAD;
                     r_num   <= w_num;
                     r_i     <= '0;
                     r_busy  <= 1'b1;
                     r_nib   <= 1'b0;
                     r_word  <= w_first_word;
                     r_rs    <= w_first_word[RS_BIT];
                     r_db    <= bus_fmt(w_first_word[7:0], B4, 1'b0);
                  end
               end
               S_LOAD: r_state <= S_SETUP;
               S_SETUP: if (w_expire) begin
                  r_state <= S_PULSE;
                  r_e     <= 1'b1;
               end
               S_PULSE: if (w_expire) begin
                  r_state <= S_HOLD;
                  r_e     <= 1'b0;
               end
               S_HOLD: if (w_expire) begin
                  if (B4 && !r_nib) begin
                     r_state <= S_SETUP;
                     r_nib   <= 1'b1;
                     r_db    <= bus_fmt(r_word[7:0], B4, 1'b1);
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
               S_WAIT: if (w_expire) begin
                  r_i <= w_next_i;
                  if (w_next_i == r_num) begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_LOAD;
                     r_nib   <= 1'b0;
                     r_word  <= w_next_word;
                     r_rs    <= w_next_word[RS_BIT];
                     r_db    <= bus_fmt(w_next_word[7:0], B4, 1'b0);
                  end
               end
               S_FIN:   r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign lcd_db = r_db;
   assign lcd_rs = r_rs;
   assign lcd_rw = 1'b0;
   assign lcd_e  = r_e & ~abort;

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 16, instruction table entries
- BUS4, 0, 1 = 4-bit nibble bus mode
- T_SETUP, 4, RS/DB setup cycles
- T_PW, 12, E high cycles
- T_HOLD, 2, hold cycles
- T_EXEC, 2000, post-instruction wait cycles
- T_LONG, 80000, wait cycles for clear/home
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, begin sequence (IDLE only)
- abort, in, 1, cancel sequence
- num_instr, in, clog2(DEPTH)+1, entries to execute
- wr_en, in, 1, table write strobe
- wr_addr, in, clog2(DEPTH), table address
- wr_data, in, 9, {rs, db[7:0]}
- busy, out, 1, sequence active
- done, out, 1, one-cycle completion pulse
- lcd_db, out, 8, LCD data bus
- lcd_e, out, 1, LCD enable
- lcd_rw, out, 1, LCD R/W
- lcd_rs, out, 1, LCD register select

Function
REQ-003 lcd_rw SHALL be constant 0.
REQ-004 The table SHALL be DEPTH x 9-bit registers, written on wr_en only when busy=0; writes while busy=1 SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, LOAD, SETUP, PULSE, HOLD, WAIT, FIN.
REQ-006 IDLE with start=1 and num_instr>0: next state LOAD, index i=0, busy=1.
REQ-007 start with num_instr=0: no E pulse; done=1 on the next cycle; remain IDLE.
REQ-008 num_instr>DEPTH SHALL be clamped to DEPTH.
REQ-009 LOAD (1 cycle): latch entry i; drive lcd_rs and lcd_db; lcd_e=0.
REQ-010 SETUP SHALL last T_SETUP cycles with lcd_e=0, followed by PULSE for T_PW cycles with lcd_e=1, followed by HOLD for T_HOLD cycles with lcd_e=0 and lcd_db/lcd_rs unchanged.
REQ-011 BUS4=1: lcd_db[7:4] carries the high nibble first, then after HOLD the low nibble repeats SETUP/PULSE/HOLD; lcd_db[3:0]=0 throughout.
REQ-012 WAIT SHALL last T_LONG cycles if rs=0 and db[7:2]=0 (clear/home), otherwise T_EXEC cycles.
REQ-013 At WAIT end, i SHALL increment; if i=num_instr the FSM goes to FIN, otherwise to LOAD.
REQ-014 FIN: done=1 for exactly one cycle, busy=0, next state IDLE.
REQ-015 8-bit per-instruction latency SHALL be 1+T_SETUP+T_PW+T_HOLD+wait cycles; BUS4 adds T_SETUP+T_PW+T_HOLD.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 abort in any non-IDLE state: lcd_e=0 in the same cycle (combinational gate), state IDLE on the next edge, busy=0, no done; abort has priority over start.
REQ-018 One shared down-counter SHALL time every phase, sized for max(T_LONG, T_EXEC, T_PW, T_SETUP, T_HOLD).

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state IDLE, i=0, busy=0, done=0, lcd_e=0, lcd_rs=0, lcd_db=0, counter=0.
REQ-020 Table contents SHALL be reset to 0.
REQ-021 Reset asserted mid-pulse SHALL drop lcd_e immediately.

Structure
REQ-022 The FSM state enum, the instruction word field positions (RS bit 8, DB bits 7:0) and the clear/home decode mask SHALL live in a shared package lcd_pkg.
REQ-023 The phase counter SHALL be the sub-module lcd_delay_timer (load value, start, expire pulse).

Verification
Bench parameters: DEPTH=8, T_SETUP=2, T_PW=5, T_HOLD=2, T_EXEC=10, T_LONG=40.
REQ-024 8-bit mode, entries {1,0x41},{1,0x42}, num_instr=2, start: two E pulses, each 5 cycles wide; rs=1; db=0x41 then 0x42; done exactly 40 cycles after start; done is one cycle wide.
REQ-025 Entry {0,0x01}, num_instr=1: WAIT lasts 40 cycles; done 50 cycles after start.
REQ-026 BUS4=1, entry {1,0xA5}: lcd_db=0xA0 during the first E pulse and 0x50 during the second; done 29 cycles after start.
REQ-027 num_instr=0: no E pulse; done 1 cycle after start. num_instr=12: exactly 8 instructions execute.
REQ-028 abort during the second PULSE: lcd_e=0 in the same cycle; busy=0 on the next cycle; no done; a new start then runs from entry 0.
REQ-029 rst_n low mid-WAIT with a wr_en while busy: all outputs 0 asynchronously, table cleared, and the ignored write leaves no effect.
